// File: rtl/processor_pkg.sv
// Shared encoding definitions for the VLIW core: slot layout, opcodes and widths.
package processor_pkg;

    localparam int SLOT_W = 32;

    localparam int OP_LSB      = 27;
    localparam int RD_LSB      = 22;
    localparam int RS1_LSB     = 17;
    localparam int RS2_LSB     = 12;
    localparam int MOV_SEL_BIT = 21;
    localparam int MOV_SRC_LSB = 16;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_SLL = 5'b00101;
    localparam logic [4:0] OP_SRL = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_LW  = 5'b01000;
    localparam logic [4:0] OP_SW  = 5'b01001;
    localparam logic [4:0] OP_MOV = 5'b10100;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm12;
    } slot_t;

endpackage

// File: rtl/processor_vliw_slot_alu.sv
// Decode and execute one bundle slot; produces register and memory write requests.
module vliw_slot_alu
    import processor_pkg::*;
#(
    parameter int DMEM_AW = 8
) (
    input  logic [SLOT_W-1:0]  slot_i,
    input  logic [31:0]        rs1_val,
    input  logic [31:0]        rs2_val,
    input  logic [31:0]        rd_val,
    input  logic [31:0]        mov_val,
    input  logic [31:0]        ld_data,
    output logic               reg_we,
    output logic [4:0]         reg_wa,
    output logic [31:0]        reg_wd,
    output logic [DMEM_AW-1:0] mem_re_addr,
    output logic               mem_we,
    output logic [DMEM_AW-1:0] mem_wa,
    output logic [31:0]        mem_wd
);
    slot_t       s;
    logic [31:0] imm_sx;
    logic [31:0] addr;
    logic        unused_addr;

    assign s           = slot_t'(slot_i);
    assign imm_sx      = {{20{s.imm12[11]}}, s.imm12};
    assign addr        = rs1_val + imm_sx;
    assign mem_re_addr = addr[DMEM_AW-1:0];
    assign mem_wa      = addr[DMEM_AW-1:0];
    assign mem_wd      = rd_val;
    assign reg_wa      = s.rd;
    assign unused_addr = ^addr[31:DMEM_AW];

    always_comb begin
        reg_we = 1'b0;
        reg_wd = '0;
        mem_we = 1'b0;
        case (s.op)
            OP_ADD: begin reg_we = 1'b1; reg_wd = rs1_val + rs2_val; end
            OP_SUB: begin reg_we = 1'b1; reg_wd = rs1_val - rs2_val; end
            OP_AND: begin reg_we = 1'b1; reg_wd = rs1_val & rs2_val; end
            OP_OR:  begin reg_we = 1'b1; reg_wd = rs1_val | rs2_val; end
            OP_XOR: begin reg_we = 1'b1; reg_wd = rs1_val ^ rs2_val; end
            OP_SLL: begin reg_we = 1'b1; reg_wd = rs1_val << rs2_val[4:0]; end
            OP_SRL: begin reg_we = 1'b1; reg_wd = rs1_val >> rs2_val[4:0]; end
            OP_SLT: begin
                reg_we = 1'b1;
                reg_wd = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
            end
            OP_LW:  begin reg_we = 1'b1; reg_wd = ld_data; end
            OP_SW:  mem_we = 1'b1;
            OP_MOV: begin
                reg_we = 1'b1;
                reg_wd = slot_i[MOV_SEL_BIT] ? {11'd0, slot_i[20:0]} : mov_val;
            end
            default: ;
        endcase
        // R0 is hardwired; SW still uses rd as its data source
        if (s.rd == 5'd0) reg_we = 1'b0;
    end

endmodule

// File: rtl/processor.sv
// VLIW core top: instruction/data memories, register file and per-slot write merge.
module processor
    import processor_pkg::*;
#(
    parameter int NSLOT      = 10,
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_we,
    input  logic [31:0]             inst_waddr,
    input  logic [SLOT_W*NSLOT-1:0] inst_wdata,
    input  logic [4:0]              dbg_raddr,
    output logic [31:0]             dbg_rdata,
    output logic [31:0]             pc
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam int BW  = SLOT_W * NSLOT;

    logic [31:0]                       pc_q, pc_d;
    logic [IAW-1:0]                    pc_nxt;
    logic [31:0][31:0]                 regs_q, regs_d;
    logic [DMEM_DEPTH-1:0][31:0]       dmem_q, dmem_d;
    logic [IMEM_DEPTH-1:0][BW-1:0]     imem_q, imem_d;
    logic [BW-1:0]                     bundle;

    logic [NSLOT-1:0]                  reg_we, mem_we;
    logic [NSLOT-1:0][4:0]             reg_wa;
    logic [NSLOT-1:0][31:0]            reg_wd, mem_wd, ld_data;
    logic [NSLOT-1:0][DAW-1:0]         mem_re_addr, mem_wa;
    logic                              unused_waddr;

    assign bundle       = imem_q[pc_q[IAW-1:0]];
    assign dbg_rdata    = regs_q[dbg_raddr];
    assign pc           = pc_q;
    assign unused_waddr = ^inst_waddr[31:IAW];

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        slot_t s;
        assign s          = slot_t'(bundle[k*SLOT_W +: SLOT_W]);
        assign ld_data[k] = dmem_q[mem_re_addr[k]];

        vliw_slot_alu #(.DMEM_AW(DAW)) u_alu (
            .slot_i      (bundle[k*SLOT_W +: SLOT_W]),
            .rs1_val     (regs_q[s.rs1]),
            .rs2_val     (regs_q[s.rs2]),
            .rd_val      (regs_q[s.rd]),
            .mov_val     (regs_q[bundle[k*SLOT_W+MOV_SRC_LSB +: 5]]),
            .ld_data     (ld_data[k]),
            .reg_we      (reg_we[k]),
            .reg_wa      (reg_wa[k]),
            .reg_wd      (reg_wd[k]),
            .mem_re_addr (mem_re_addr[k]),
            .mem_we      (mem_we[k]),
            .mem_wa      (mem_wa[k]),
            .mem_wd      (mem_wd[k])
        );
    end

    always_comb begin
        pc_nxt = pc_q[IAW-1:0] + IAW'(1);
        pc_d   = 32'(pc_nxt);
        regs_d = regs_q;
        dmem_d = dmem_q;
        // ascending order: the highest-numbered slot overrides earlier writes
        for (int k = 0; k < NSLOT; k++) begin
            if (reg_we[k]) regs_d[reg_wa[k]] = reg_wd[k];
            if (mem_we[k]) dmem_d[mem_wa[k]] = mem_wd[k];
        end
        imem_d = imem_q;
        if (inst_we) imem_d[inst_waddr[IAW-1:0]] = inst_wdata;
    end

    always_ff @(posedge clk) begin
        imem_q <= imem_d;
        if (rst) begin
            pc_q   <= '0;
            regs_q <= '0;
            dmem_q <= '0;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            dmem_q <= dmem_d;
        end
    end

endmodule

// File: tb/tb_processor.sv
// Directed bench for the VLIW core: loads a short program and checks architectural state.
module tb_processor;
    localparam int NSLOT = 10;
    localparam int BW    = 32 * NSLOT;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_we;
    logic [31:0]   inst_waddr;
    logic [BW-1:0] inst_wdata;
    logic [4:0]    dbg_raddr;
    logic [31:0]   dbg_rdata;
    logic [31:0]   pc;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] prog [64];

    processor #(.NSLOT(NSLOT), .IMEM_DEPTH(64), .DMEM_DEPTH(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_we    (inst_we),
        .inst_waddr (inst_waddr),
        .inst_wdata (inst_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        dbg_raddr = r;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] op, rd, rs1, rs2);
        return {op, rd, rs1, rs2, 12'h000};
    endfunction

    function automatic logic [31:0] i_op(input logic [4:0] op, rd, rs1, input logic [11:0] imm);
        return {op, rd, rs1, 5'd0, imm};
    endfunction

    function automatic logic [31:0] mov_i(input logic [4:0] rd, input logic [20:0] v);
        return {5'b10100, rd, 1'b1, v};
    endfunction

    task automatic put(input int b, input int k, input logic [31:0] w);
        prog[b][32*k +: 32] = w;
    endtask

    initial begin
        rst = 1'b1; inst_we = 1'b0; inst_waddr = '0; inst_wdata = '0; dbg_raddr = '0;
        for (int i = 0; i < 64; i++) prog[i] = '0;

        put(1, 0, 32'hA0A00004);                    // MOV r2,4
        put(2, 0, 32'hA0E00005);                    // MOV r3,5
        put(3, 0, mov_i(5'd10, 21'h0DEAD));
        put(3, 1, mov_i(5'd11, 21'd16));
        put(3, 2, mov_i(5'd12, 21'h0BEEF));
        put(4, 9, 32'h02062000);                    // ADD r8,r3,r2
        put(4, 0, r_op(5'b00101, 5'd13, 5'd10, 5'd11));
        put(5, 0, r_op(5'b00011, 5'd4, 5'd13, 5'd12));
        put(5, 1, mov_i(5'd2, 21'd7));
        put(5, 2, r_op(5'b00000, 5'd9, 5'd2, 5'd2));
        put(6, 0, mov_i(5'd5, 21'd1));
        put(6, 6, mov_i(5'd5, 21'd2));
        put(6, 3, mov_i(5'd0, 21'd9));
        put(6, 7, i_op(5'b01001, 5'd4, 5'd0, 12'hFFF)); // SW r4,-1(r0)
        put(6, 8, i_op(5'b01000, 5'd14, 5'd0, 12'hFFF)); // LW same word, old value
        put(7, 0, i_op(5'b01000, 5'd6, 5'd0, 12'hFFF));
        put(7, 1, r_op(5'b00001, 5'd15, 5'd3, 5'd2));
        put(7, 2, r_op(5'b00100, 5'd17, 5'd10, 5'd12));
        put(7, 3, r_op(5'b00010, 5'd18, 5'd10, 5'd12));
        put(8, 0, r_op(5'b00111, 5'd16, 5'd15, 5'd3));
        put(8, 2, r_op(5'b00111, 5'd19, 5'd3, 5'd15));
        put(8, 3, r_op(5'b00110, 5'd20, 5'd4, 5'd11));
        put(8, 5, 32'hA5440000);                    // MOV r21,R4
        put(8, 1, i_op(5'b01001, 5'd2, 5'd0, 12'h003));
        put(8, 4, i_op(5'b01001, 5'd3, 5'd0, 12'h003));
        put(9, 0, i_op(5'b01000, 5'd22, 5'd0, 12'h003));
        put(9, 1, i_op(5'b01000, 5'd23, 5'd13, 12'h0FF));

        // instruction writes are accepted while reset is held
        #1;
        for (int i = 0; i < 64; i++) begin
            inst_we = 1'b1; inst_waddr = i; inst_wdata = prog[i];
            step(1);
        end
        inst_we = 1'b0;
        step(2);
        check("reset_pc", pc, 32'd0);
        for (int r = 0; r < 32; r++) chk_reg($sformatf("reset_r%0d", r), 5'(r), 32'd0);

        rst = 1'b0;
        step(5);
        check("pc5", pc, 32'd5);
        chk_reg("mov_r2", 5'd2, 32'd4);
        chk_reg("mov_r3", 5'd3, 32'd5);
        chk_reg("add_r8", 5'd8, 32'd9);
        chk_reg("sll_r13", 5'd13, 32'hDEAD0000);

        step(1);
        chk_reg("par_r2", 5'd2, 32'd7);
        chk_reg("par_r9", 5'd9, 32'd8);
        chk_reg("or_r4", 5'd4, 32'hDEADBEEF);

        step(1);
        chk_reg("conflict_r5", 5'd5, 32'd2);
        chk_reg("r0_zero", 5'd0, 32'd0);
        chk_reg("lw_old_r14", 5'd14, 32'd0);

        step(1);
        chk_reg("lw_r6", 5'd6, 32'hDEADBEEF);
        chk_reg("sub_r15", 5'd15, 32'hFFFFFFFE);
        chk_reg("xor_r17", 5'd17, 32'h00006042);
        chk_reg("and_r18", 5'd18, 32'h00009EAD);

        step(1);
        chk_reg("slt_r16", 5'd16, 32'd1);
        chk_reg("slt_r19", 5'd19, 32'd0);
        chk_reg("srl_r20", 5'd20, 32'h0000DEAD);
        chk_reg("movr_r21", 5'd21, 32'hDEADBEEF);

        step(1);
        chk_reg("sw_conflict_r22", 5'd22, 32'd5);
        chk_reg("addr_wrap_r23", 5'd23, 32'hDEADBEEF);
        check("pc10", pc, 32'd10);

        step(53);
        check("pc63", pc, 32'd63);
        step(1);
        check("pc_wrap", pc, 32'd0);
        step(2);
        chk_reg("rerun_r2", 5'd2, 32'd4);

        // reset edge at pc=2 discards MOV r3,5
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_pc", pc, 32'd0);
        chk_reg("rst_r2", 5'd2, 32'd0);
        chk_reg("rst_r3", 5'd3, 32'd0);
        chk_reg("rst_r8", 5'd8, 32'd0);
        step(2);
        check("rst_pc2", pc, 32'd2);
        chk_reg("imem_kept_r2", 5'd2, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
